// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit async SRAM between fetch and data ports as two half accesses per word
module sram_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wre,
    output logic [15:0]       ram_dout,
    output logic              ram_doe,
    input  logic [15:0]       ram_din,
    output logic              busy
);
    localparam logic [2:0] IDLE = 3'd0, LO = 3'd1, GAP = 3'd2, HI = 3'd3, ACK = 3'd4;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic              sel_mem, we;
    logic [ADDR_W-2:0] addr;
    logic [31:0]       wdata;
    logic [15:0]       lo_half;
    logic              g_we;
    logic [ADDR_W-2:0] g_addr;
    logic              unused_msb;
    // the data port wins whenever both request in IDLE
    assign g_we       = mem_req & mem_we;
    assign g_addr     = mem_req ? mem_addr[ADDR_W-2:0] : if_addr[ADDR_W-2:0];
    assign unused_msb = if_addr[ADDR_W-1] ^ mem_addr[ADDR_W-1];
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_mem   <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            lo_half   <= '0;
            ram_addr  <= '0;
            ram_wre   <= 1'b1;
            ram_dout  <= '0;
            ram_doe   <= 1'b0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: if (mem_req || if_req) begin
                    state    <= LO;
                    cnt      <= '0;
                    sel_mem  <= mem_req;
                    we       <= g_we;
                    addr     <= g_addr;
                    wdata    <= mem_wdata;
                    busy     <= 1'b1;
                    ram_addr <= {g_addr, 1'b0};
                    ram_wre  <= ~g_we;
                    ram_doe  <= g_we;
                    ram_dout <= mem_wdata[15:0];
                end
                LO: if (cnt == LAST) begin
                    state   <= GAP;
                    lo_half <= ram_din;
                    ram_wre <= 1'b1;
                end else cnt <= cnt + 1'b1;
                // write strobe is off here, so the address may move to the high half safely
                GAP: begin
                    state    <= HI;
                    cnt      <= '0;
                    ram_addr <= {addr, 1'b1};
                    ram_wre  <= ~we;
                    ram_dout <= wdata[31:16];
                end
                HI: if (cnt == LAST) begin
                    state   <= ACK;
                    ram_wre <= 1'b1;
                    ram_doe <= 1'b0;
                    if_ack  <= ~sel_mem;
                    mem_ack <= sel_mem;
                    if (!we && sel_mem) mem_rdata <= {ram_din, lo_half};
                    if (!we && !sel_mem) if_rdata <= {ram_din, lo_half};
                end else cnt <= cnt + 1'b1;
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random word traffic against a word-level memory model
module tb_sram_port_arbiter;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [17:0] if_addr = '0, mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ack, mem_ack, ram_wre, ram_doe, busy;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout, ram_din;
    logic        if3_req = 1'b0;
    logic [17:0] if3_addr = '0;
    logic [31:0] if3_rdata, mem3_rdata;
    logic        if3_ack, mem3_ack, ram3_wre, ram3_doe, busy3;
    logic [17:0] ram3_addr;
    logic [15:0] ram3_dout, ram3_din = '0;
    logic [15:0] sram [2048];
    logic [31:0] ref_w [1024];
    int checks = 0, failures = 0;

    sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_dout(ram_dout), .ram_doe(ram_doe),
        .ram_din(ram_din), .busy(busy));

    sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_ack(if3_ack),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(18'h0), .mem_wdata(32'h0),
        .mem_rdata(mem3_rdata), .mem_ack(mem3_ack),
        .ram_addr(ram3_addr), .ram_wre(ram3_wre), .ram_dout(ram3_dout), .ram_doe(ram3_doe),
        .ram_din(ram3_din), .busy(busy3));

    assign ram_din = sram[ram_addr[10:0]];
    always @(posedge clock) if (!ram_wre && ram_doe) sram[ram_addr[10:0]] <= ram_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_txn(input logic m, input logic we, input logic [17:0] a, input logic [31:0] wd);
        int n = 0;
        logic ack = 1'b0;
        logic [17:0] lo_a = {a[16:0], 1'b0};
        logic [17:0] hi_a = {a[16:0], 1'b1};
        logic [31:0] oth = m ? if_rdata : mem_rdata;
        logic [31:0] own = m ? mem_rdata : if_rdata;
        logic [31:0] exp = we ? own : ref_w[a[9:0]];
        while (!ack && n < 20) begin
            @(negedge clock);
            n++;
            ack = m ? mem_ack : if_ack;
            if (n == 1) begin
                chk("lo_addr", ram_addr, lo_a);
                chk("lo_wre", ram_wre, !we);
                chk("lo_doe", ram_doe, we);
                chk("busy", busy, 1);
                if (we) chk("lo_dout", ram_dout, wd[15:0]);
            end
            if (n == 2) begin
                chk("gap_wre", ram_wre, 1);
                chk("gap_addr", ram_addr, lo_a);
            end
            if (n == 3) begin
                chk("hi_addr", ram_addr, hi_a);
                chk("hi_wre", ram_wre, !we);
                chk("hi_doe", ram_doe, we);
                if (we) chk("hi_dout", ram_dout, wd[31:16]);
            end
        end
        chk("ack_edges", n, 4);
        chk("ack_doe_wre", {ram_doe, ram_wre}, 2'b01);
        chk("rdata", m ? mem_rdata : if_rdata, exp);
        chk("other_rdata", m ? if_rdata : mem_rdata, oth);
        if (m && we) ref_w[a[9:0]] = wd;
        if (m) mem_req = 1'b0; else if_req = 1'b0;
        @(negedge clock);
        chk("ack_pulse", {if_ack, mem_ack}, 2'b00);
    endtask

    task automatic run1(input logic m, input logic we, input logic [17:0] a, input logic [31:0] wd);
        mem_we = we;
        if (m) begin
            mem_req = 1'b1; mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        finish_txn(m, m & we, a, wd);
    endtask

    initial begin
        logic [15:0] lo, hi;
        logic [31:0] wd;
        logic ack3;
        int n;
        for (int i = 0; i < 1024; i++) begin
            lo = 16'($urandom);
            hi = 16'($urandom);
            sram[2*i] <= lo;
            sram[2*i+1] <= hi;
            ref_w[i] = {hi, lo};
        end
        repeat (3) @(negedge clock);
        chk("rst_wre", ram_wre, 1);
        chk("rst_doe", ram_doe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {if_ack, mem_ack}, 2'b00);
        chk("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
        chk("rst_addr_dout", {ram_addr, ram_dout}, 34'h0);
        chk("rst3_state", {busy3, ram3_wre, ram3_doe, if3_ack, mem3_ack}, 5'b01000);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", {busy, ram_wre, ram_doe}, 3'b010);
        // fetch of a preloaded word
        sram[12'h20] <= 16'hBEEF;
        sram[12'h21] <= 16'hDEAD;
        ref_w[10'h10] = 32'hDEADBEEF;
        run1(1'b0, 1'b0, 18'h00010, 32'h0);
        chk("fetch_word", if_rdata, 32'hDEADBEEF);
        // data write then fetch of the same word
        run1(1'b1, 1'b1, 18'h00003, 32'h12345678);
        run1(1'b0, 1'b0, 18'h00003, 32'h0);
        chk("fetch_after_write", if_rdata, 32'h12345678);
        // simultaneous requests: data first, then fetch five edges after its ack
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00040;
        if_req = 1'b1; if_addr = 18'h00041;
        finish_txn(1'b1, 1'b0, 18'h00040, 32'h0);
        chk("fetch_still_pending", if_req, 1);
        finish_txn(1'b0, 1'b0, 18'h00041, 32'h0);
        // reset in the middle of the high half of a write
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00300; mem_wdata = 32'hA5A55A5A;
        repeat (3) @(negedge clock);
        chk("pre_reset_hi_wre", {ram_wre, ram_addr}, {1'b0, 18'h00601});
        reset = 1'b1;
        mem_req = 1'b0;
        if_req = 1'b1; if_addr = 18'h00022;
        @(negedge clock);
        chk("mid_rst_wre_doe", {ram_wre, ram_doe}, 2'b10);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acks", {if_ack, mem_ack}, 2'b00);
        chk("mid_rst_rdata", {if_rdata, mem_rdata}, 64'h0);
        chk("mid_rst_addr", ram_addr, 18'h0);
        reset = 1'b0;
        finish_txn(1'b0, 1'b0, 18'h00022, 32'h0);
        // random traffic; bit 17 is set at random to show the MSB is discarded
        for (int i = 0; i < 40; i++) begin
            wd = $urandom;
            run1(1'($urandom % 2), 1'($urandom % 2),
                 {1'($urandom % 2), 8'h00, 9'($urandom_range(0, 511))}, wd);
        end
        // three-cycle halves: only the third cycle of each half carries the real data
        if3_req = 1'b1; if3_addr = 18'h00055;
        n = 0; ack3 = 1'b0;
        while (!ack3 && n < 20) begin
            @(negedge clock);
            n++;
            ack3 = if3_ack;
            if (n >= 1 && n <= 4) chk("w3_lo_addr", ram3_addr, 18'h000AA);
            if (n >= 5 && n <= 7) chk("w3_hi_addr", ram3_addr, 18'h000AB);
            if (n == 4) chk("w3_gap_wre", ram3_wre, 1);
            ram3_din = (n == 3) ? 16'h1357 : (n == 7) ? 16'h2468 : 16'(16'h0BAD ^ n);
        end
        chk("w3_ack_edges", n, 8);
        chk("w3_rdata", if3_rdata, 32'h24681357);
        chk("w3_mem_rdata", mem3_rdata, 32'h0);
        if3_req = 1'b0;
        @(negedge clock);
        chk("w3_ack_pulse", if3_ack, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single 16-bit asynchronous SRAM between the instruction-fetch port and the data-memory port of the pipelined MIPS core. Each 32-bit word access is split into two sequenced 16-bit half accesses: low half first, then high half. The block arbitrates between the two requesters and returns a one-cycle acknowledge per completed word. It sits between the Fetch/Memory stages and the top-level SRAM pins; the top level owns the tristate on the data bus.

Parameters:
ADDR_W, 18, SRAM halfword address width
WAIT_CYCLES, 1, cycles each half access is held on the bus (>=1)

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch requests a word read; held until if_ack
if_addr  in  ADDR_W  fetch word address; stable while if_req
if_rdata  out  32  fetched word; valid in if_ack cycle, held afterwards
if_ack  out  1  one-cycle completion pulse for fetch
mem_req  in  1  data-memory request; held until mem_ack
mem_we  in  1  1=write, 0=read; stable while mem_req
mem_addr  in  ADDR_W  data word address; stable while mem_req
mem_wdata  in  32  write data; stable while mem_req
mem_rdata  out  32  read word; valid in mem_ack cycle, held afterwards
mem_ack  out  1  one-cycle completion pulse for data port
ram_addr  out  ADDR_W  SRAM halfword address
ram_wre  out  1  SRAM write enable, active low
ram_dout  out  16  data driven toward SRAM
ram_doe  out  1  1 = top level drives ram_dout onto the bus
ram_din  in  16  data read from the SRAM bus
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values (next edge with reset=1, including mid-transaction): state=IDLE; ram_addr=0; ram_wre=1; ram_doe=0; ram_dout=0; if_ack=mem_ack=0; if_rdata=mem_rdata=0; busy=0. Any in-flight transaction is abandoned and no ack is issued.
- All outputs are registered.
- FSM states:
  - IDLE -> LO when any request is pending.
  - LO, held WAIT_CYCLES cycles.
  - GAP, 1 cycle.
  - HI, held WAIT_CYCLES cycles.
  - ACK, 1 cycle, then -> IDLE.
- Arbitration happens only in IDLE:
  - mem_req wins over if_req (the older instruction has priority).
  - The winner and its we/addr/wdata are latched at the grant edge.
  - Requests arriving while busy wait; they are not dropped.
- Address mapping: LO uses ram_addr={addr[ADDR_W-2:0],1'b0}; HI uses {addr[ADDR_W-2:0],1'b1}. The address MSB is discarded.
- Writes:
  - LO: ram_doe=1, ram_dout=wdata[15:0].
  - HI: ram_doe=1, ram_dout=wdata[31:16].
  - ram_wre=0 throughout LO and HI.
  - In GAP, ram_wre=1 and ram_addr is unchanged, so address never changes while ram_wre=0.
- Reads: ram_wre=1 and ram_doe=0 throughout.
  - ram_din is captured into the low half at the last cycle of LO.
  - ram_din is captured into the high half at the last cycle of HI.
  - The word is copied to the winner's rdata at the ACK-state entry edge.
  - The other port's rdata is unchanged.
- Writes leave both rdata outputs unchanged.
- ACK state: the winner's ack=1 for exactly one cycle. ram_doe=0, ram_wre=1.
- Latency with WAIT_CYCLES=1: request seen at edge E0 (IDLE) gives LO @E0, GAP @E1, HI @E2, ack high @E3–E4. General latency is 2*WAIT_CYCLES+2 edges from grant to ack.
- Requester protocol: deassert req or present a new request on the edge after ack. Because ACK always returns to IDLE, a request still high in IDLE is treated as a new transaction.
- Simultaneous requests in IDLE: mem is served, then fetch is served from the next IDLE. There is no starvation guard, since the MEM stage issues at most one access per instruction.
- mem_we with if_req ignored: fetch is always a read.

Test Plan:
- Reset, then idle: ram_wre=1, ram_doe=0, busy=0, both acks 0, rdata=0.
- Fetch read addr 0x00010, SRAM halfword 0x00020=0xBEEF and 0x00021=0xDEAD. Required: ram_addr 0x00020 then 0x00021; if_ack pulses 1 cycle 4 edges after grant; if_rdata=0xDEADBEEF.
- Data write addr 0x00003, data 0x12345678. Required:
  - LO: ram_addr=0x00006, ram_dout=0x5678, ram_wre=0.
  - GAP: ram_wre=1.
  - HI: ram_addr=0x00007, ram_dout=0x1234.
  - mem_ack pulses once; a subsequent fetch of 0x00003 returns 0x12345678.
- if_req and mem_req asserted the same cycle. Required: mem served first with mem_ack; if_ack follows exactly 5 edges later; neither request lost.
- Reset asserted during HI of a write. Required: next edge ram_wre=1, ram_doe=0, state IDLE, no ack; after release a held if_req starts a fresh LO.
- WAIT_CYCLES=3 read. Required: each of LO and HI spans 3 cycles; capture happens on the third cycle; ack comes 8 edges after grant.
